fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of decode/ALU; feeds the 3-bit opcode map (ADD, ADDI, AND, XOR, STR, LOAD, BHS, SFT) to the decode stage.
- Owns the PC, drives the synchronous instruction ROM, and presents one instruction at a time to decode via a valid/ready handshake.
- Applies branch redirects resolved by downstream and stops on a halt encoding.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction ROM port plus the valid/ready instruction
// channel to decode, with branch redirects returning from downstream.
interface fetch_unit_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
);
  logic               imem_rd;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         opcode;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;

  // Handshake: a transfer happens on a rising edge where instr_valid and
  // instr_ready are both high; instr/opcode/instr_pc stay stable while valid
  // is high without ready, and branch_taken/branch_target matter only then.
  modport master (
    output imem_rd, imem_addr, instr, opcode, instr_pc, instr_valid,
    input  imem_data, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_rd, imem_addr, instr, opcode, instr_pc, instr_valid,
    output imem_data, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a one-cycle-latency ROM and
// presents each instruction to decode, applying BHS redirects and halting.
module fetch_unit #(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF,
  parameter int                 CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             done,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       dbg_state,
  fetch_unit_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_VALID  = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  localparam logic [2:0] OP_BHS = 3'b110;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         opcode;
  logic               xfer;

  assign opcode = instr_q[INSTR_W-1 -: 3];
  assign xfer   = (state_q == S_VALID) && bus.instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        instr_d    = bus.imem_data;
        instr_pc_d = pc_q;
        state_d    = S_VALID;
      end
      S_VALID: begin
        if (xfer) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          // Halt takes priority, so a BHS-looking halt word never redirects.
          if (instr_q == HALT_INSTR) begin
            state_d = S_HALTED;
          end else begin
            if ((opcode == OP_BHS) && bus.branch_taken) begin
              pc_d = bus.branch_target;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_rd     = (state_q == S_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = opcode;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = (state_q == S_VALID);
  assign done            = (state_q == S_HALTED);
  assign instr_count     = cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a program-level model of PC sequencing and retirement count.
module tb_fetch_unit;
  localparam int PC_W = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W = 16;
  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd2, ST_VALID = 3'd3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic done;
  logic [CNT_W-1:0] instr_count;
  logic [2:0] dbg_state;
  logic [8:0] rom [1024];
  logic [PC_W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_INSTR(HALT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .done(done),
    .instr_count(instr_count), .dbg_state(dbg_state), .bus(bus)
  );

  // ---------------- clock / reset / ROM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.imem_rd) bus.imem_data <= rom[bus.imem_addr];

  // ---------------- driver tasks ----------------
  task automatic fill_rom();
    for (int i = 0; i < 1024; i++) begin
      logic [8:0] v;
      v = 9'($urandom_range(0, 510));
      rom[i] = v;
    end
  endtask

  task automatic do_reset();
    bus.instr_ready = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int cyc = 0;
    while (!bus.instr_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    ok = bus.instr_valid;
  endtask

  function automatic logic [PC_W-1:0] model_next(logic [PC_W-1:0] pc, logic [8:0] ins,
                                                 bit bt, logic [PC_W-1:0] tgt);
    if (ins[8:6] == 3'b110 && bt) return tgt;
    return PC_W'((int'(pc) + 1) % 1024);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests++;
    if (dbg_state !== ST_IDLE || bus.instr_valid !== 1'b0 || bus.imem_rd !== 1'b0 ||
        done !== 1'b0 || instr_count !== '0 || bus.instr !== '0 ||
        bus.instr_pc !== '0 || bus.imem_addr !== '0) begin
      fails++;
      $display("FAIL reset_state: state=%0d valid=%b rd=%b done=%b cnt=%0d instr=%h pc=%0d addr=%0d, want all zero",
               dbg_state, bus.instr_valid, bus.imem_rd, done, instr_count, bus.instr,
               bus.instr_pc, bus.imem_addr);
    end
  endtask

  task automatic test_sequential();
    fill_rom();
    rom[0] = 9'h001; rom[1] = 9'h045; rom[2] = 9'h0A3; rom[3] = HALT;
    do_reset();
    bus.instr_ready = 1'b1;
    pulse_start();
    tests++;
    if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 10'd0) begin
      fails++;
      $display("FAIL seq_first_rd: rd=%b addr=%0d, want rd=1 addr=0", bus.imem_rd, bus.imem_addr);
    end
    @(negedge clk);
    tests++;
    if (bus.imem_rd !== 1'b0 || bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL seq_wait: rd=%b valid=%b, want 0 0", bus.imem_rd, bus.instr_valid);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [8:0] w;
      w = rom[i];
      tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== PC_W'(i) ||
          bus.instr !== w || bus.opcode !== w[8:6]) begin
        fails++;
        $display("FAIL seq_instr%0d: valid=%b pc=%0d instr=%h op=%b, want 1 %0d %h %b",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, bus.opcode, i, w, w[8:6]);
      end
      repeat (i < 3 ? 3 : 1) @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || instr_count !== 16'd4 || bus.instr_valid !== 1'b0 || bus.imem_rd !== 1'b0) begin
      fails++;
      $display("FAIL seq_halt: done=%b cnt=%0d valid=%b rd=%b, want 1 4 0 0",
               done, instr_count, bus.instr_valid, bus.imem_rd);
    end
  endtask

  task automatic run_expected(input string name, input bit bt, input logic [PC_W-1:0] tgt);
    bit ok;
    logic [PC_W-1:0] e;
    bus.instr_ready = 1'b1;
    bus.branch_taken = bt;
    bus.branch_target = tgt;
    pulse_start();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (bus.imem_rd !== 1'b1 || bus.imem_addr !== e) begin
        fails++;
        $display("FAIL %s_addr: rd=%b addr=%0d, want 1 %0d", name, bus.imem_rd, bus.imem_addr, e);
      end
      wait_valid(ok);
      tests++;
      if (!ok || bus.instr_pc !== e || bus.instr !== rom[e]) begin
        fails++;
        $display("FAIL %s_pc: valid=%b pc=%0d instr=%h, want 1 %0d %h",
                 name, ok, bus.instr_pc, bus.instr, e, rom[e]);
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done: done=%b, want 1", name, done);
    end
  endtask

  task automatic test_branch();
    fill_rom();
    rom[0] = 9'h001; rom[1] = 9'h005; rom[2] = 9'h185; rom[10] = HALT;
    do_reset();
    exp_q = '{10'd0, 10'd1, 10'd2, 10'd10};
    run_expected("branch", 1'b1, 10'd10);
  endtask

  task automatic test_wrap();
    fill_rom();
    rom[0] = 9'h180; rom[1023] = 9'h003; rom[1] = 9'h181; rom[2] = HALT;
    do_reset();
    // 0 (BHS taken) -> 1023 -> wraps to 0 -> BHS taken again, but target now 1
    bus.instr_ready = 1'b1;
    exp_q = '{10'd0, 10'd1023, 10'd0};
    run_expected_partial();
    exp_q = '{10'd1, 10'd2};
    bus.branch_target = 10'd2;
    run_expected_tail();
  endtask

  task automatic run_expected_partial();
    bit ok;
    logic [PC_W-1:0] e;
    bus.branch_taken = 1'b1;
    bus.branch_target = 10'd1023;
    pulse_start();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (exp_q.size() == 0) bus.branch_target = 10'd1;
      tests++;
      if (bus.imem_rd !== 1'b1 || bus.imem_addr !== e) begin
        fails++;
        $display("FAIL wrap_addr: rd=%b addr=%0d, want 1 %0d", bus.imem_rd, bus.imem_addr, e);
      end
      wait_valid(ok);
      tests++;
      if (!ok || bus.instr_pc !== e) begin
        fails++;
        $display("FAIL wrap_pc: valid=%b pc=%0d, want 1 %0d", ok, bus.instr_pc, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_expected_tail();
    bit ok;
    logic [PC_W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (bus.imem_addr !== e) begin
        fails++;
        $display("FAIL wrap_tail_addr: addr=%0d, want %0d", bus.imem_addr, e);
      end
      wait_valid(ok);
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || instr_count !== 16'd5) begin
      fails++;
      $display("FAIL wrap_done: done=%b cnt=%0d, want 1 5", done, instr_count);
    end
  endtask

  task automatic test_backpressure_and_start();
    bit ok;
    logic [8:0] hold_instr;
    logic [PC_W-1:0] hold_pc;
    fill_rom();
    rom[0] = 9'h012; rom[1] = HALT;
    do_reset();
    pulse_start();
    wait_valid(ok);
    hold_instr = bus.instr;
    hold_pc = bus.instr_pc;
    tests++;
    if (!ok || hold_instr !== 9'h012 || hold_pc !== 10'd0) begin
      fails++;
      $display("FAIL bp_first: valid=%b instr=%h pc=%0d, want 1 012 0", ok, hold_instr, hold_pc);
    end
    for (int c = 0; c < 5; c++) begin
      bus.branch_taken = 1'($urandom_range(0, 1));
      start = (c == 2);
      @(negedge clk);
      tests++;
      if (bus.instr_valid !== 1'b1 || bus.imem_rd !== 1'b0 || bus.instr !== hold_instr ||
          bus.instr_pc !== hold_pc || instr_count !== 16'd0 || dbg_state !== ST_VALID) begin
        fails++;
        $display("FAIL bp_stall%0d: valid=%b rd=%b instr=%h pc=%0d cnt=%0d state=%0d",
                 c, bus.instr_valid, bus.imem_rd, bus.instr, bus.instr_pc, instr_count, dbg_state);
      end
    end
    start = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    tests++;
    if (instr_count !== 16'd1 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 10'd1) begin
      fails++;
      $display("FAIL bp_release: cnt=%0d valid=%b addr=%0d, want 1 0 1", instr_count, bus.instr_valid, bus.imem_addr);
    end
    wait_valid(ok);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || instr_count !== 16'd2) begin
      fails++;
      $display("FAIL halted: done=%b cnt=%0d, want 1 2", done, instr_count);
    end
    pulse_start();
    tests++;
    if (done !== 1'b0 || instr_count !== 16'd0 || bus.imem_addr !== 10'd0 || bus.imem_rd !== 1'b1) begin
      fails++;
      $display("FAIL restart: done=%b cnt=%0d addr=%0d rd=%b, want 0 0 0 1",
               done, instr_count, bus.imem_addr, bus.imem_rd);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_rom();
    rom[0] = 9'h0AB;
    do_reset();
    bus.instr_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    tests++;
    if (dbg_state !== ST_WAIT) begin
      fails++;
      $display("FAIL mid_in_wait: state=%0d, want %0d", dbg_state, ST_WAIT);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (bus.instr_valid !== 1'b0 || bus.imem_rd !== 1'b0 || bus.imem_addr !== '0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL mid_reset: valid=%b rd=%b addr=%0d state=%0d, want 0 0 0 0",
               bus.instr_valid, bus.imem_rd, bus.imem_addr, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rom[0] = 9'h066;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.instr_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL mid_idle: valid=%b state=%0d, want 0 0", bus.instr_valid, dbg_state);
    end
    bus.instr_ready = 1'b0;
    pulse_start();
    wait_valid(ok);
    tests++;
    if (!ok || bus.instr_pc !== 10'd0 || bus.instr !== 9'h066) begin
      fails++;
      $display("FAIL mid_refetch: valid=%b pc=%0d instr=%h, want 1 0 066", ok, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [PC_W-1:0] m_pc;
    logic [CNT_W-1:0] m_cnt;
    bit bt;
    logic [PC_W-1:0] tgt;
    fill_rom();
    do_reset();
    m_pc = '0;
    m_cnt = '0;
    pulse_start();
    for (int n = 0; n < 60; n++) begin
      wait_valid(ok);
      tests++;
      if (!ok || bus.instr_pc !== m_pc || bus.instr !== rom[m_pc] || instr_count !== m_cnt) begin
        fails++;
        $display("FAIL rand%0d: valid=%b pc=%0d instr=%h cnt=%0d, want 1 %0d %h %0d",
                 n, ok, bus.instr_pc, bus.instr, instr_count, m_pc, rom[m_pc], m_cnt);
      end
      repeat ($urandom_range(0, 3)) begin
        bus.branch_taken = 1'($urandom_range(0, 1));
        bus.branch_target = PC_W'($urandom_range(0, 1023));
        @(negedge clk);
      end
      bt = 1'($urandom_range(0, 1));
      tgt = PC_W'($urandom_range(0, 1023));
      bus.branch_taken = bt;
      bus.branch_target = tgt;
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      bus.branch_taken = 1'($urandom_range(0, 1));
      m_cnt = m_cnt + 1'b1;
      m_pc = model_next(m_pc, rom[m_pc], bt, tgt);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_backpressure_and_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
